// File: rtl/calib_trg_seq.sv
// calib_trg_seq: resyncs the raw calibration pulse into one CLK40 CAL_TRG with
// programmable delay, width and dead time. Define CALTRG_RETRIG_EN for one pending retrigger.
module calib_trg_seq #(
  parameter int DLY_W = 8,
  parameter int PW_W  = 4,
  parameter int CNT_W = 12
) (
  input  logic             CLK40,
  input  logic             RST_RESYNC,
  input  logic             TRG_PULSE,
  input  logic             ENABLE,
  input  logic [DLY_W-1:0] DELAY,
  input  logic [PW_W-1:0]  PLS_WIDTH,
  input  logic [DLY_W-1:0] DEADTIME,
  output logic             CAL_TRG,
  output logic             BUSY,
  output logic [CNT_W-1:0] TRGCNT,
  output logic [CNT_W-1:0] DROPCNT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_FIRE,
    S_DEAD
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [DLY_W-1:0] cnt;
  logic [DLY_W-1:0] cnt_nx;
  logic [PW_W-1:0]  pw_q;
  logic [DLY_W-1:0] dt_q;
  logic             s1;
  logic             s2;
  logic             s3;
  logic [1:0]       fill;
  logic             armed;
  logic             rise;
  logic             start;
  logic             drop;
`ifdef CALTRG_RETRIG_EN
  logic             pend;
  logic             pend_nx;
`endif

  assign rise = s2 & ~s3 & armed;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    start    = 1'b0;
    drop     = 1'b0;
`ifdef CALTRG_RETRIG_EN
    pend_nx  = pend;
`endif
    unique case (state)
      S_IDLE: start = rise & ENABLE;
      S_DELAY: begin
        drop = rise;
        if (cnt == '0) begin
          state_nx = S_FIRE;
          cnt_nx   = DLY_W'(pw_q);
        end else begin
          cnt_nx = cnt - DLY_W'(1);
        end
      end
      S_FIRE: begin
        drop = rise;
        if (cnt == '0) begin
          if (dt_q != '0) begin
            state_nx = S_DEAD;
            cnt_nx   = dt_q - DLY_W'(1);
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          cnt_nx = cnt - DLY_W'(1);
        end
      end
      S_DEAD: begin
`ifdef CALTRG_RETRIG_EN
        if (rise & ~pend) pend_nx = 1'b1;
        else drop = rise;
        if (cnt == '0) begin
          state_nx = S_IDLE;
          start    = pend_nx;
          pend_nx  = 1'b0;
        end else begin
          cnt_nx = cnt - DLY_W'(1);
        end
`else
        drop = rise;
        if (cnt == '0) state_nx = S_IDLE;
        else cnt_nx = cnt - DLY_W'(1);
`endif
      end
      default: state_nx = S_IDLE;
    endcase
    // a start always uses the live config, which is latched in the same cycle
    if (start) begin
      if (DELAY == '0) begin
        state_nx = S_FIRE;
        cnt_nx   = DLY_W'(PLS_WIDTH);
      end else begin
        state_nx = S_DELAY;
        cnt_nx   = DELAY - DLY_W'(1);
      end
    end
  end

  always_ff @(posedge CLK40) begin
    if (RST_RESYNC) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      fill    <= 2'b00;
      armed   <= 1'b0;
      state   <= S_IDLE;
      cnt     <= '0;
      pw_q    <= '0;
      dt_q    <= '0;
      CAL_TRG <= 1'b0;
      BUSY    <= 1'b0;
      TRGCNT  <= '0;
      DROPCNT <= '0;
    end else begin
      s1   <= TRG_PULSE;
      s2   <= s1;
      s3   <= s2;
      fill <= {fill[0], 1'b1};
      // s2 holds a real sample only once fill[1] is set; a level held through reset never arms
      if (fill[1] & ~s2) armed <= 1'b1;
      state <= state_nx;
      cnt   <= cnt_nx;
      if (start) begin
        pw_q <= PLS_WIDTH;
        dt_q <= DEADTIME;
      end
      CAL_TRG <= (state_nx == S_FIRE);
      BUSY    <= (state_nx != S_IDLE);
      if (state_nx == S_FIRE && state != S_FIRE)
        TRGCNT <= TRGCNT + CNT_W'(1);
      if (drop && DROPCNT != '1)
        DROPCNT <= DROPCNT + CNT_W'(1);
    end
  end

`ifdef CALTRG_RETRIG_EN
  always_ff @(posedge CLK40) begin
    if (RST_RESYNC) pend <= 1'b0;
    else pend <= pend_nx;
  end
`endif

endmodule
